rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4:1 data mux among four requesters.
//  Owns the mux selects {s1,s0}: grants one requester at a time, holds the grant
//  while its req stays high, and forces rotation after HOLD_MAX cycles.
//  Sits between the requester ports and the mux output o.
// PARAMETERS
//  DW        1  width of each data input d0..d3 and of output o
//  HOLD_MAX  8  maximum consecutive grant cycles per requester; legal range 2..255
// PORTS
//  clk    in   1   single clock; all state updates on rising edge
//  rst_n  in   1   synchronous, active-low reset, sampled on rising edge of clk
//  req    in   4   request lines; req[i] high = requester i wants the mux
//  d0     in   DW  requester 0 data
//  d1     in   DW  requester 1 data
//  d2     in   DW  requester 2 data
//  d3     in   DW  requester 3 data
//  gnt    out  4   one-hot grant, registered; all-zero when idle
//  s1     out  1   mux select MSB, registered
//  s0     out  1   mux select LSB, registered
//  busy   out  1   high while any grant is active, registered
//  o      out  DW  combinational: busy ? d[{s1,s0}] : 0
// BEHAVIOUR
//  - Reset (rst_n low at edge): gnt=0, {s1,s0}=0, busy=0, o=0.
//    Internal state on reset: ptr=0, cnt=0, state=IDLE. Reset overrides everything,
//    including mid-grant: the grant drops at that same edge.
//  - ptr is the highest-priority index. Search order is ptr, ptr+1, ... mod 4 (3 wraps to 0).
//  - IDLE: if req!=0, grant the first set req in search order at the next edge.
//    Set gnt, {s1,s0}=idx, busy=1, cnt=0, and go to GRANT. Latency req->gnt = 1 cycle.
//    If req=0, stay in IDLE with all outputs 0.
//  - GRANT, req[idx]=1 and cnt<HOLD_MAX-1: hold the grant and increment cnt.
//    Other req bits are ignored in this case.
//  - GRANT, req[idx]=0 (voluntary release): set ptr=idx+1 mod 4.
//    Arbitrate among the remaining requests in the same edge (no idle bubble).
//    Other requester found: new gnt, cnt=0. None found: go to IDLE, gnt=0, busy=0.
//    {s1,s0} keep their last value while idle.
//  - GRANT, req[idx]=1 and cnt==HOLD_MAX-1 (forced rotation): set ptr=idx+1 mod 4.
//    Mask req[idx] and arbitrate the rest. If another requester is found, grant it.
//    If none, re-grant idx with cnt=0. busy stays 1.
//  - A req that rises on the same edge as a release is eligible in that arbitration.
//  - gnt is always one-hot or zero. {s1,s0} always equals the index of the set gnt bit.
//  - o switches in the same cycle as {s1,s0}. It carries no register latency.
//  - cnt is $clog2(HOLD_MAX) bits wide and never exceeds HOLD_MAX-1.
// STRUCTURE
//  - Shared header rr_arb_defs.vh holds the constants:
//    NREQ=4, SELW=2, ST_IDLE=1'b0, ST_GRANT=1'b1.
//  - Shared header also holds the function next_rr(req_masked, ptr) -> {found, idx}.
//  - Sub-module mux4_dw: parameterised DW-wide 4:1 mux.
//    Inputs s1, s0, d0..d3; output y. Gated by busy in this block.
//  - Top-level contents: FSM, ptr, cnt, and the registered grant/select.
// TESTING
//  - Reset: hold rst_n=0 for 2 cycles with req=4'b1111.
//    Required: gnt=0, busy=0, o=0. First grant after release is gnt=4'b0001.
//  - Rotation: hold req=4'b1111, each requester drops req for 1 cycle after 2 grant cycles.
//    Required grant order: 0001,0010,0100,1000,0001 (wrap), with no idle cycle between.
//  - Hold limit: HOLD_MAX=4, req=4'b0011 held high.
//    Required: gnt=0001 for exactly 4 cycles, then 0010 for 4, then 0001 again.
//  - Sole requester: HOLD_MAX=4, only req=4'b0100 held high for 10 cycles.
//    Required: gnt=0100 continuously, busy=1, cnt wraps every 4 cycles.
//  - Data path: DW=1, grant requester 2 with d2 toggling 0,1,0 and d0=d1=d3=1.
//    Required: o follows d2 in the same cycle. o=0 once idle.
//  - Reset mid-grant: gnt=1000, assert rst_n=0 at one edge.
//    Required: gnt=0, busy=0 after that edge; ptr restarts at 0 with req=4'b1001 -> gnt=0001.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_pkg : shared constants, FSM state type and round-robin search
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rr_mux_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [SELW-1:0] idx;
  } pick_t;

  // Walk from the farthest offset back to ptr so the nearest set request wins.
  function automatic pick_t next_rr(input logic [NREQ-1:0] req_masked,
                                    input logic [SELW-1:0] ptr);
    pick_t           res;
    logic [SELW-1:0] k;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = ptr + SELW'(i);
      if (req_masked[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_if : requester-side request/data bundle and arbiter outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rr_mux_arbiter_if
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DW = 1
);

  logic [NREQ-1:0] req;
  logic [DW-1:0]   d0;
  logic [DW-1:0]   d1;
  logic [DW-1:0]   d2;
  logic [DW-1:0]   d3;
  logic [NREQ-1:0] gnt;
  logic            s1;
  logic            s0;
  logic            busy;
  logic [DW-1:0]   o;

  modport master (
    output req, d0, d1, d2, d3,
    input  gnt, s1, s0, busy, o
  );

  modport slave (
    input  req, d0, d1, d2, d3,
    output gnt, s1, s0, busy, o
  );

endinterface

`default_nettype wire

// File: rtl/rr_mux_arbiter_mux4_dw.sv
// ---------------------------------------------------------------------------
// mux4_dw : DW-wide 4:1 data multiplexer selected by {s1,s0}
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux4_dw #(
  parameter int DW = 1
) (
  input  logic          s1,
  input  logic          s0,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  output logic [DW-1:0] y
);

  always_comb begin
    y = d0;
    case ({s1, s0})
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter : round-robin owner of a shared 4:1 mux with hold-limit rotation
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DW       = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_mux_arbiter_if.slave     bus
);

  localparam int CW = $clog2(HOLD_MAX);

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] sel;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic            busy;

  logic            cur_req;
  logic            at_limit;
  logic [SELW-1:0] search_ptr;
  logic [NREQ-1:0] req_masked;
  pick_t           pick;
  logic [DW-1:0]   mux_y;

  // While granted, search starts after the owner and excludes it, which covers
  // both voluntary release (its req is already low) and forced rotation.
  always_comb begin
    cur_req    = bus.req[sel];
    at_limit   = (cnt == CW'(HOLD_MAX - 1));
    search_ptr = ptr;
    req_masked = bus.req;
    if (state == ST_GRANT) begin
      search_ptr = sel + 1'b1;
      req_masked = bus.req & ~(NREQ'(1) << sel);
    end
    pick = next_rr(req_masked, search_ptr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      sel   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick.found) begin
            state <= ST_GRANT;
            gnt   <= NREQ'(1) << pick.idx;
            sel   <= pick.idx;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (cur_req && !at_limit) begin
            cnt <= cnt + 1'b1;
          end else begin
            ptr <= sel + 1'b1;
            if (pick.found) begin
              gnt <= NREQ'(1) << pick.idx;
              sel <= pick.idx;
              cnt <= '0;
            end else if (cur_req) begin
              cnt <= '0;
            end else begin
              // Select lines deliberately keep their last value while idle.
              state <= ST_IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mux4_dw #(
    .DW (DW)
  ) u_mux (
    .s1 (sel[1]),
    .s0 (sel[0]),
    .d0 (bus.d0),
    .d1 (bus.d1),
    .d2 (bus.d2),
    .d3 (bus.d3),
    .y  (mux_y)
  );

  assign bus.gnt  = gnt;
  assign bus.s1   = sel[1];
  assign bus.s0   = sel[0];
  assign bus.busy = busy;
  assign bus.o    = busy ? mux_y : '0;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter : vector-table bench for rr_mux_arbiter (DW=1, HOLD_MAX=4)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_mux_arbiter;

  logic clk;
  logic rst_n;

  rr_mux_arbiter_if #(.DW(1)) bus ();

  rr_mux_arbiter #(
    .DW       (1),
    .HOLD_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d is packed {d3,d2,d1,d0}; expected values are the outputs after the edge.
  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] sel;
    logic       o;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] dd,
                     input logic [3:0] g, input logic b, input logic [1:0] s,
                     input logic oo);
    vec_t v;
    v.rst_n = r; v.req = rq; v.d = dd; v.gnt = g; v.busy = b; v.sel = s; v.o = oo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.d0  = '0;
    bus.d1  = '0;
    bus.d2  = '0;
    bus.d3  = '0;

    // Reset with all requests high, then first grant goes to requester 0.
    add(0, 4'b1111, 4'b1111, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b1111, 4'b1111, 4'b0000, 0, 2'd0, 0);
    add(1, 4'b1111, 4'b0001, 4'b0001, 1, 2'd0, 1);
    // Rotation: each owner drops for one cycle after two grant cycles.
    add(1, 4'b1111, 4'b1110, 4'b0001, 1, 2'd0, 0);
    add(1, 4'b1110, 4'b0010, 4'b0010, 1, 2'd1, 1);
    add(1, 4'b1111, 4'b1101, 4'b0010, 1, 2'd1, 0);
    add(1, 4'b1101, 4'b0100, 4'b0100, 1, 2'd2, 1);
    add(1, 4'b1111, 4'b1011, 4'b0100, 1, 2'd2, 0);
    add(1, 4'b1011, 4'b1000, 4'b1000, 1, 2'd3, 1);
    add(1, 4'b1111, 4'b0111, 4'b1000, 1, 2'd3, 0);
    add(1, 4'b0111, 4'b0001, 4'b0001, 1, 2'd0, 1);
    // Request rising on the release edge is eligible.
    add(1, 4'b0100, 4'b0100, 4'b0100, 1, 2'd2, 1);
    add(1, 4'b0000, 4'b1111, 4'b0000, 0, 2'd2, 0);
    // Hold limit with two requesters.
    add(0, 4'b0011, 4'b1111, 4'b0000, 0, 2'd0, 0);
    add(1, 4'b0011, 4'b0001, 4'b0001, 1, 2'd0, 1);
    add(1, 4'b0011, 4'b0010, 4'b0001, 1, 2'd0, 0);
    add(1, 4'b0011, 4'b0001, 4'b0001, 1, 2'd0, 1);
    add(1, 4'b0011, 4'b1110, 4'b0001, 1, 2'd0, 0);
    add(1, 4'b0011, 4'b0010, 4'b0010, 1, 2'd1, 1);
    add(1, 4'b0011, 4'b0001, 4'b0010, 1, 2'd1, 0);
    add(1, 4'b0011, 4'b1111, 4'b0010, 1, 2'd1, 1);
    add(1, 4'b0011, 4'b1101, 4'b0010, 1, 2'd1, 0);
    add(1, 4'b0011, 4'b0001, 4'b0001, 1, 2'd0, 1);
    add(1, 4'b0000, 4'b1111, 4'b0000, 0, 2'd0, 0);
    // Sole requester 2 across hold-limit boundaries, d2 toggling.
    for (int k = 0; k < 10; k++)
      add(1, 4'b0100, (k % 2 == 1) ? 4'b1111 : 4'b1011, 4'b0100, 1, 2'd2, k % 2 == 1);
    add(1, 4'b0000, 4'b1111, 4'b0000, 0, 2'd2, 0);
    // Reset mid-grant, then pointer restarts at 0.
    add(1, 4'b1000, 4'b1000, 4'b1000, 1, 2'd3, 1);
    add(0, 4'b1001, 4'b1111, 4'b0000, 0, 2'd0, 0);
    add(1, 4'b1001, 4'b0001, 4'b0001, 1, 2'd0, 1);
    add(1, 4'b0000, 4'b1111, 4'b0000, 0, 2'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n   = vecs[i].rst_n;
      bus.req = vecs[i].req;
      bus.d0  = vecs[i].d[0];
      bus.d1  = vecs[i].d[1];
      bus.d2  = vecs[i].d[2];
      bus.d3  = vecs[i].d[3];
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard row %0d: got empty queue, expected an entry", i);
      end else begin
        e = exp_q.pop_front();
        check("gnt",    i, int'(bus.gnt),            int'(e.gnt));
        check("busy",   i, int'(bus.busy),           int'(e.busy));
        check("sel",    i, int'({bus.s1, bus.s0}),   int'(e.sel));
        check("o",      i, int'(bus.o),              int'(e.o));
        check("onehot", i, int'($onehot0(bus.gnt)),  1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
